toggle_cover_tracker: RTL and testbench

//  Producer side of the toggle-coverage valid interface. Watches WIDTH design signals,

---
 rtl/toggle_cover_pkg.sv | 14 +
 rtl/cover_prio_enc.sv | 22 ++
 rtl/toggle_cover_tracker.sv | 131 +++++++++++++
 tb/tb_toggle_cover_tracker.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
// rtl/toggle_cover_pkg.sv - shared types and helpers for the toggle coverage tracker
package toggle_cover_pkg;

    localparam int COVER_IDX_W = 64;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    typedef struct packed {
        logic [COVER_IDX_W-1:0] idx;
    } evt_t;

endpackage

// File: rtl/cover_prio_enc.sv
// rtl/cover_prio_enc.sv - lowest-set-bit priority encoder
module cover_prio_enc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan downward so the lowest set bit is the last (winning) assignment
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/toggle_cover_tracker.sv
// rtl/toggle_cover_tracker.sv - per-bit toggle coverage with valid pulses and index event stream
module toggle_cover_tracker
    import toggle_cover_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 38253
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            signal,
    output logic [WIDTH-1:0]            valid,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [COVER_IDX_W-1:0]      evt_index,
    output logic [cnt_width(WIDTH)-1:0] hit_count,
    output logic                        all_hit
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
        $error("toggle_cover_tracker: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [WIDTH-1:0] rise_seen;
    logic [WIDTH-1:0] fall_seen;
    logic [WIDTH-1:0] covered;
    logic [WIDTH-1:0] pending;
    evt_t             evt_q;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise_seen_nxt;
    logic [WIDTH-1:0] fall_seen_nxt;
    logic [WIDTH-1:0] new_bits;
    logic [WIDTH-1:0] pend_all;
    logic [WIDTH-1:0] pend_pop;
    logic [CNT_W-1:0] new_cnt;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             load;

    always_comb begin
        rise          = '0;
        fall          = '0;
        if (en && primed) begin
            rise = ~prev & signal;
            fall = prev & ~signal;
        end
        rise_seen_nxt = rise_seen | rise;
        fall_seen_nxt = fall_seen | fall;
        new_bits      = rise_seen_nxt & fall_seen_nxt & ~covered;
    end

    always_comb begin
        new_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_cnt = new_cnt + CNT_W'(new_bits[i]);
        end
    end

    // Newly covered bits are visible to the encoder in the cycle they appear
    assign pend_all = pending | new_bits;

    cover_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req (pend_all),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign load     = ~evt_valid | evt_ready;
    assign pend_pop = pend_all & ~(WIDTH'(1) << enc_idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            primed    <= 1'b0;
            rise_seen <= '0;
            fall_seen <= '0;
            covered   <= '0;
            pending   <= '0;
            valid     <= '0;
            evt_valid <= 1'b0;
            evt_q     <= '0;
            hit_count <= '0;
        end else if (clear) begin
            primed    <= 1'b0;
            rise_seen <= '0;
            fall_seen <= '0;
            covered   <= '0;
            pending   <= '0;
            valid     <= '0;
            evt_valid <= 1'b0;
            hit_count <= '0;
        end else begin
            if (en) begin
                prev   <= signal;
                primed <= 1'b1;
            end
            rise_seen <= rise_seen_nxt;
            fall_seen <= fall_seen_nxt;
            covered   <= covered | new_bits;
            valid     <= new_bits;
            hit_count <= hit_count + new_cnt;
            if (load) begin
                evt_valid <= enc_any;
                if (enc_any) begin
                    evt_q.idx <= COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(enc_idx);
                    pending   <= pend_pop;
                end else begin
                    pending   <= pend_all;
                end
            end else begin
                pending <= pend_all;
            end
        end
    end

    assign evt_index = evt_q.idx;
    assign all_hit   = (hit_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_tracker.sv
// tb/tb_toggle_cover_tracker.sv - directed self-checking bench for toggle_cover_tracker
module tb_toggle_cover_tracker;

    localparam int WIDTH = 32;
    localparam int CI    = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        clear;
    logic [31:0] signal;
    logic [31:0] valid;
    logic        evt_valid;
    logic        evt_ready;
    logic [63:0] evt_index;
    logic [5:0]  hit_count;
    logic        all_hit;

    int n_pass  = 0;
    int n_total = 0;

    toggle_cover_tracker #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (CI),
        .COVER_TOTAL (38253)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .signal    (signal),
        .valid     (valid),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_index (evt_index),
        .hit_count (hit_count),
        .all_hit   (all_hit)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; clear = 1'b0; signal = '0; evt_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; clear = 1'b0; signal = '0; evt_ready = 1'b0;
        #2;
        n_total++; if (valid !== 32'h0) $display("FAIL reset_valid: got %0h expected 0", valid); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid: got %0b expected 0", evt_valid); else n_pass++;
        n_total++; if (evt_index !== 64'd0) $display("FAIL reset_evt_index: got %0d expected 0", evt_index); else n_pass++;
        n_total++; if (hit_count !== 6'd0) $display("FAIL reset_hit_count: got %0d expected 0", hit_count); else n_pass++;
        n_total++; if (all_hit !== 1'b0) $display("FAIL reset_all_hit: got %0b expected 0", all_hit); else n_pass++;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_bit();
        do_reset();
        en = 1'b1; signal = 32'h0; tick();
        signal = 32'h8; tick();
        n_total++; if (valid !== 32'h0) $display("FAIL single_rise_only: got %0h expected 0", valid); else n_pass++;
        signal = 32'h0; tick();
        n_total++; if (valid !== 32'h8) $display("FAIL single_valid: got %0h expected 8", valid); else n_pass++;
        n_total++; if (evt_valid !== 1'b1) $display("FAIL single_evt_valid: got %0b expected 1", evt_valid); else n_pass++;
        n_total++; if (evt_index !== 64'(CI + 3)) $display("FAIL single_evt_index: got %0d expected %0d", evt_index, CI + 3); else n_pass++;
        n_total++; if (hit_count !== 6'd1) $display("FAIL single_hit_count: got %0d expected 1", hit_count); else n_pass++;
        tick();
        n_total++; if (valid !== 32'h0) $display("FAIL single_pulse_width: got %0h expected 0", valid); else n_pass++;
        n_total++; if (evt_index !== 64'(CI + 3)) $display("FAIL single_hold: got %0d expected %0d", evt_index, CI + 3); else n_pass++;
        evt_ready = 1'b1; tick();
        n_total++; if (evt_valid !== 1'b0) $display("FAIL single_drained: got %0b expected 0", evt_valid); else n_pass++;
    endtask

    task automatic test_prime_only();
        do_reset();
        evt_ready = 1'b1;
        en = 1'b1; signal = 32'hFFFF_FFFF; tick();
        signal = 32'h0; tick();
        tick();
        n_total++; if (valid !== 32'h0) $display("FAIL prime_valid: got %0h expected 0", valid); else n_pass++;
        n_total++; if (hit_count !== 6'd0) $display("FAIL prime_hit_count: got %0d expected 0", hit_count); else n_pass++;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL prime_evt_valid: got %0b expected 0", evt_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; signal = 32'h0; tick();
        signal = 32'h8000_0021; tick();
        signal = 32'h0; tick();
        n_total++; if (valid !== 32'h8000_0021) $display("FAIL bp_valid: got %0h expected 80000021", valid); else n_pass++;
        n_total++; if (hit_count !== 6'd3) $display("FAIL bp_hit_count: got %0d expected 3", hit_count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (evt_valid !== 1'b1 || evt_index !== 64'(CI))
                $display("FAIL bp_hold%0d: got v=%0b idx=%0d expected v=1 idx=%0d", k, evt_valid, evt_index, CI);
            else n_pass++;
            if (k < 3) tick();
        end
        evt_ready = 1'b1; tick();
        n_total++; if (evt_valid !== 1'b1 || evt_index !== 64'(CI + 5)) $display("FAIL bp_second: got v=%0b idx=%0d expected v=1 idx=%0d", evt_valid, evt_index, CI + 5); else n_pass++;
        tick();
        n_total++; if (evt_valid !== 1'b1 || evt_index !== 64'(CI + 31)) $display("FAIL bp_third: got v=%0b idx=%0d expected v=1 idx=%0d", evt_valid, evt_index, CI + 31); else n_pass++;
        tick();
        n_total++; if (evt_valid !== 1'b0) $display("FAIL bp_empty: got %0b expected 0", evt_valid); else n_pass++;
    endtask

    task automatic test_all_bits();
        do_reset();
        evt_ready = 1'b1;
        en = 1'b1; signal = 32'h0; tick();
        signal = 32'hFFFF_FFFF; tick();
        signal = 32'h0; tick();
        n_total++; if (valid !== 32'hFFFF_FFFF) $display("FAIL all_valid: got %0h expected ffffffff", valid); else n_pass++;
        n_total++; if (hit_count !== 6'd32) $display("FAIL all_hit_count: got %0d expected 32", hit_count); else n_pass++;
        n_total++; if (all_hit !== 1'b1) $display("FAIL all_hit_flag: got %0b expected 1", all_hit); else n_pass++;
        for (int k = 0; k < 32; k++) begin
            n_total++;
            if (evt_valid !== 1'b1 || evt_index !== 64'(CI + k))
                $display("FAIL all_evt%0d: got v=%0b idx=%0d expected v=1 idx=%0d", k, evt_valid, evt_index, CI + k);
            else n_pass++;
            if (k == 0) signal = 32'hFFFF_FFFF;
            else if (k == 1) signal = 32'h0;
            tick();
            if (k <= 1) begin
                n_total++; if (valid !== 32'h0) $display("FAIL all_round2_valid%0d: got %0h expected 0", k, valid); else n_pass++;
            end
        end
        n_total++; if (evt_valid !== 1'b0) $display("FAIL all_round2_evt: got %0b expected 0", evt_valid); else n_pass++;
        n_total++; if (hit_count !== 6'd32) $display("FAIL all_round2_hit: got %0d expected 32", hit_count); else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        en = 1'b1; signal = 32'h0; tick();
        signal = 32'h3; tick();
        signal = 32'h0; tick();
        n_total++; if (evt_valid !== 1'b1 || hit_count !== 6'd2) $display("FAIL clr_setup: got v=%0b hit=%0d expected v=1 hit=2", evt_valid, hit_count); else n_pass++;
        clear = 1'b1; tick();
        clear = 1'b0;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL clr_evt_valid: got %0b expected 0", evt_valid); else n_pass++;
        n_total++; if (hit_count !== 6'd0) $display("FAIL clr_hit_count: got %0d expected 0", hit_count); else n_pass++;
        signal = 32'h1; tick();
        signal = 32'h0; tick();
        n_total++; if (valid !== 32'h0) $display("FAIL clr_needs_prime: got %0h expected 0", valid); else n_pass++;
        signal = 32'h1; tick();
        n_total++; if (valid !== 32'h1) $display("FAIL clr_recover_valid: got %0h expected 1", valid); else n_pass++;
        n_total++; if (evt_valid !== 1'b1 || evt_index !== 64'(CI)) $display("FAIL clr_recover_evt: got v=%0b idx=%0d expected v=1 idx=%0d", evt_valid, evt_index, CI); else n_pass++;
        n_total++; if (hit_count !== 6'd1) $display("FAIL clr_recover_hit: got %0d expected 1", hit_count); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; signal = 32'h0; tick();
        signal = 32'h3; tick();
        signal = 32'h0; tick();
        #1;
        reset = 1'b0;
        #1;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL ar_evt_valid: got %0b expected 0", evt_valid); else n_pass++;
        n_total++; if (valid !== 32'h0) $display("FAIL ar_valid: got %0h expected 0", valid); else n_pass++;
        n_total++; if (evt_index !== 64'd0) $display("FAIL ar_evt_index: got %0d expected 0", evt_index); else n_pass++;
        n_total++; if (hit_count !== 6'd0) $display("FAIL ar_hit_count: got %0d expected 0", hit_count); else n_pass++;
        en = 1'b0; evt_ready = 1'b1;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (evt_valid !== 1'b0 || valid !== 32'h0)
                $display("FAIL ar_stale%0d: got v=%0b valid=%0h expected v=0 valid=0", k, evt_valid, valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_prime_only();
        test_backpressure();
        test_all_bits();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
